// File: rtl/loop_seq.sv
// Two-level nested-loop index sequencer: walks (outer, inner) pairs over a
// programmed bound and hands them out one per valid/ready transfer.
module loop_seq #(
    parameter  int INNER_MAX = 31,
    parameter  int OUTER_MAX = 7,
    localparam int IW        = $clog2(INNER_MAX + 1),
    localparam int OW        = $clog2(OUTER_MAX + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [IW-1:0] cfg_inner_last,
    input  logic [OW-1:0] cfg_outer_last,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_inner,
    output logic [OW-1:0] out_outer,
    output logic          out_inner_last,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] INNER_CAP = IW'(INNER_MAX);
    localparam logic [OW-1:0] OUTER_CAP = OW'(OUTER_MAX);

    logic [1:0]    state_q,  state_d;
    logic [IW-1:0] inner_q,  inner_d;
    logic [OW-1:0] outer_q,  outer_d;
    logic [IW-1:0] ibound_q, ibound_d;
    logic [OW-1:0] obound_q, obound_d;

    logic run_s;
    logic xfer_s;
    logic inner_at_s;
    logic outer_at_s;

    assign run_s      = (state_q == S_RUN);
    assign xfer_s     = run_s & out_ready;
    assign inner_at_s = (inner_q == ibound_q);
    assign outer_at_s = (outer_q == obound_q);

    // Next-state logic; indices are held at zero whenever no walk is in progress.
    always_comb begin
        state_d  = state_q;
        inner_d  = inner_q;
        outer_d  = outer_q;
        ibound_d = ibound_q;
        obound_d = obound_q;
        case (state_q)
            S_IDLE: begin
                // abort in IDLE suppresses a same-cycle start
                if (start && !abort) begin
                    ibound_d = (cfg_inner_last > INNER_CAP) ? INNER_CAP : cfg_inner_last;
                    obound_d = (cfg_outer_last > OUTER_CAP) ? OUTER_CAP : cfg_outer_last;
                    inner_d  = '0;
                    outer_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    inner_d = '0;
                    outer_d = '0;
                    state_d = S_IDLE;
                end else if (xfer_s) begin
                    if (!inner_at_s) begin
                        inner_d = inner_q + IW'(1);
                    end else begin
                        inner_d = '0;
                        if (!outer_at_s) begin
                            outer_d = outer_q + OW'(1);
                        end else begin
                            outer_d = '0;
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // done lasts one cycle whether or not abort arrives with it
                inner_d = '0;
                outer_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                inner_d = '0;
                outer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            inner_q  <= '0;
            outer_q  <= '0;
            ibound_q <= '0;
            obound_q <= '0;
        end else begin
            state_q  <= state_d;
            inner_q  <= inner_d;
            outer_q  <= outer_d;
            ibound_q <= ibound_d;
            obound_q <= obound_d;
        end
    end

    assign out_valid      = run_s;
    assign out_inner      = inner_q;
    assign out_outer      = outer_q;
    assign out_inner_last = run_s & inner_at_s;
    assign out_last       = run_s & inner_at_s & outer_at_s;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);

endmodule
